fifo_dpram_sclk: RTL and testbench



---
 rtl/fifo_pkg.sv | 15 +
 rtl/dpram_sclk.sv | 30 +++
 rtl/fifo_dpram_sclk.sv | 123 ++++++++++++
 tb/tb_fifo_dpram_sclk.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared defaults and sizing helpers for the single-clock DPRAM FIFO.
package fifo_pkg;

    localparam int DEFAULT_DATA_W = 10;
    localparam int DEFAULT_ADDR_W = 3;

    // Legal threshold ranges: AF in 1..DEPTH, AE in 0..DEPTH-1.
    localparam int AF_THRESH_MIN = 1;
    localparam int AE_THRESH_MIN = 0;

    function automatic int cnt_w(input int addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/dpram_sclk.sv
// Single-clock dual-port RAM: one write port and one registered read port.
module dpram_sclk #(
    parameter int DATA_W = 10,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_rdata;

    // Read data holds its last value whenever re is low.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
        if (re) begin
            r_rdata <= r_mem[raddr];
        end
    end

    assign rdata = r_rdata;

endmodule

// File: rtl/fifo_dpram_sclk.sv
// Single-clock FIFO on dpram_sclk: pointers, occupancy, flow-control flags
// and sticky overflow/underflow errors.
module fifo_dpram_sclk
    import fifo_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int ADDR_W    = DEFAULT_ADDR_W,
    parameter int AF_THRESH = 6,
    parameter int AE_THRESH = 2
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  wr_en,
    input  logic [DATA_W-1:0]     data_in,
    input  logic                  rd_en,
    output logic [DATA_W-1:0]     data_out,
    output logic                  data_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_W:0]       count,
    output logic                  err_overflow,
    output logic                  err_underflow
);

    localparam int DEPTH  = 2**ADDR_W;
    localparam int CW     = cnt_w(ADDR_W);
    localparam int AF_EFF = (AF_THRESH >= AF_THRESH_MIN && AF_THRESH <= DEPTH) ? AF_THRESH : DEPTH;
    localparam int AE_EFF = (AE_THRESH >= AE_THRESH_MIN && AE_THRESH <= DEPTH - 1) ? AE_THRESH : 0;
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] C_AF    = CW'(AF_EFF);
    localparam logic [CW-1:0] C_AE    = CW'(AE_EFF);

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic [CW-1:0]     w_count_nxt;
    logic              r_full;
    logic              r_empty;
    logic              r_afull;
    logic              r_aempty;
    logic              r_ovf;
    logic              r_unf;
    logic              r_valid;
    logic              r_rd_seen;
    logic              w_push;
    logic              w_pop;
    logic [DATA_W-1:0] w_rdata;

    // Handshake: a push (pop) is accepted in a cycle where wr_en (rd_en) is
    // high and the registered full (empty) flag is low; otherwise it is
    // dropped and only the matching sticky error flag records it.
    assign w_push = wr_en & ~r_full;
    assign w_pop  = rd_en & ~r_empty;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CW'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_full    <= 1'b0;
            r_empty   <= 1'b1;
            r_afull   <= 1'b0;
            r_aempty  <= 1'b1;
            r_ovf     <= 1'b0;
            r_unf     <= 1'b0;
            r_valid   <= 1'b0;
            r_rd_seen <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            r_count   <= w_count_nxt;
            r_full    <= (w_count_nxt == C_DEPTH);
            r_empty   <= (w_count_nxt == '0);
            r_afull   <= (w_count_nxt >= C_AF);
            r_aempty  <= (w_count_nxt <= C_AE);
            r_ovf     <= r_ovf | (wr_en & r_full);
            r_unf     <= r_unf | (rd_en & r_empty);
            r_valid   <= w_pop;
            r_rd_seen <= r_rd_seen | w_pop;
        end
    end

    dpram_sclk #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (w_push),
        .waddr (r_wr_ptr),
        .wdata (data_in),
        .re    (w_pop),
        .raddr (r_rd_ptr),
        .rdata (w_rdata)
    );

    // The RAM read register has no reset; mask it until a post-reset pop
    // refreshes it so data_out reads 0 out of reset.
    assign data_out      = r_rd_seen ? w_rdata : '0;
    assign data_valid    = r_valid;
    assign full          = r_full;
    assign empty         = r_empty;
    assign almost_full   = r_afull;
    assign almost_empty  = r_aempty;
    assign count         = r_count;
    assign err_overflow  = r_ovf;
    assign err_underflow = r_unf;

endmodule

// File: tb/tb_fifo_dpram_sclk.sv
// Scenario bench for fifo_dpram_sclk against a queue-based reference model.
module tb_fifo_dpram_sclk;

    localparam int DW    = 10;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          reset_L;
    logic          wr_en;
    logic [DW-1:0] data_in;
    logic          rd_en;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [AW:0]   count;
    logic          err_overflow;
    logic          err_underflow;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_dout;
    logic          exp_valid;
    logic          exp_ovf;
    logic          exp_unf;

    always #5 clk = ~clk;

    fifo_dpram_sclk #(
        .DATA_W    (DW),
        .ADDR_W    (AW),
        .AF_THRESH (6),
        .AE_THRESH (2)
    ) dut (
        .clk           (clk),
        .reset_L       (reset_L),
        .wr_en         (wr_en),
        .data_in       (data_in),
        .rd_en         (rd_en),
        .data_out      (data_out),
        .data_valid    (data_valid),
        .full          (full),
        .empty         (empty),
        .almost_full   (almost_full),
        .almost_empty  (almost_empty),
        .count         (count),
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow)
    );

    task automatic model_clear();
        exp_q.delete();
        exp_dout  = '0;
        exp_valid = 1'b0;
        exp_ovf   = 1'b0;
        exp_unf   = 1'b0;
    endtask

    // One clock of stimulus; the model applies FIFO rules to the pre-edge occupancy.
    task automatic step(input logic we, input logic [DW-1:0] d, input logic re);
        bit was_full;
        bit was_empty;
        was_full  = (exp_q.size() == DEPTH);
        was_empty = (exp_q.size() == 0);
        wr_en   = we;
        data_in = d;
        rd_en   = re;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        if (we && was_full)  exp_ovf = 1'b1;
        if (re && was_empty) exp_unf = 1'b1;
        exp_valid = re && !was_empty;
        if (exp_valid) exp_dout = exp_q.pop_front();
        if (we && !was_full) exp_q.push_back(d);
    endtask

    task automatic test_reset();
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        data_in = '0;
        reset_L = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #2 reset_L = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
        checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL reset_aempty got %b exp 1", almost_empty); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        checks++; if (data_out !== 10'h000) begin errors++; $display("FAIL reset_dout got %h exp 000", data_out); end
        checks++; if ({full, almost_full, data_valid, err_overflow, err_underflow} !== 5'b0) begin
            errors++; $display("FAIL reset_misc got %b exp 00000", {full, almost_full, data_valid, err_overflow, err_underflow});
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b1, DW'(i), 1'b0);
            checks++; if (count !== 4'(i)) begin errors++; $display("FAIL fill_count got %0d exp %0d", count, i); end
            checks++; if (almost_full !== (i >= 6)) begin errors++; $display("FAIL fill_afull at %0d got %b", i, almost_full); end
            checks++; if (full !== (i == DEPTH)) begin errors++; $display("FAIL fill_full at %0d got %b", i, full); end
            checks++; if (almost_empty !== (i <= 2)) begin errors++; $display("FAIL fill_aempty at %0d got %b", i, almost_empty); end
        end
    endtask

    task automatic test_drain();
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b0, '0, 1'b1);
            checks++; if (data_out !== DW'(i)) begin errors++; $display("FAIL drain_data got %h exp %h", data_out, DW'(i)); end
            checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL drain_valid got %b exp 1", data_valid); end
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty got %b exp 1", empty); end
        step(1'b0, '0, 1'b0);
        checks++; if (data_valid !== 1'b0 || data_out !== 10'h008) begin
            errors++; $display("FAIL drain_hold got v=%b d=%h exp v=0 d=008", data_valid, data_out);
        end
    endtask

    task automatic test_wrap();
        int n;
        for (int r = 0; r < 2; r++) begin
            n = 5 + r;
            for (int i = 0; i < n; i++) step(1'b1, DW'($urandom_range(0, 1023)), 1'b0);
            checks++; if (count !== 4'(exp_q.size())) begin errors++; $display("FAIL wrap_count got %0d exp %0d", count, exp_q.size()); end
            for (int i = 0; i < n; i++) begin
                step(1'b0, '0, 1'b1);
                checks++; if (data_out !== exp_dout || data_valid !== 1'b1) begin
                    errors++; $display("FAIL wrap_data got %h/%b exp %h/1", data_out, data_valid, exp_dout);
                end
            end
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < DEPTH; i++) step(1'b1, DW'($urandom_range(0, 'h3FE)), 1'b0);
        step(1'b1, 10'h3FF, 1'b0);
        checks++; if (err_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", err_overflow); end
        checks++; if (count !== 4'd8 || full !== 1'b1) begin errors++; $display("FAIL ovf_count got %0d full %b exp 8 1", count, full); end
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, '0, 1'b1);
            checks++; if (data_out === 10'h3FF || data_out !== exp_dout) begin
                errors++; $display("FAIL ovf_data got %h exp %h", data_out, exp_dout);
            end
        end
    endtask

    task automatic test_underflow();
        step(1'b0, '0, 1'b1);
        checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL unf_flag got %b exp 1", err_underflow); end
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL unf_valid got %b exp 0", data_valid); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) step(1'b1, DW'($urandom_range(0, 1023)), 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, DW'($urandom_range(0, 1023)), 1'b1);
            checks++; if (count !== 4'd4) begin errors++; $display("FAIL b2b_count got %0d exp 4", count); end
            checks++; if (data_out !== exp_dout || data_valid !== 1'b1) begin
                errors++; $display("FAIL b2b_data got %h/%b exp %h/1", data_out, data_valid, exp_dout);
            end
        end
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
        checks++; if (data_out !== exp_dout || empty !== 1'b1) begin errors++; $display("FAIL b2b_tail got %h exp %h", data_out, exp_dout); end
    endtask

    task automatic test_push_pop_empty();
        logic [DW-1:0] v;
        v = DW'($urandom_range(0, 1023));
        step(1'b1, v, 1'b1);
        checks++; if (count !== 4'd1 || data_valid !== 1'b0) begin
            errors++; $display("FAIL ppe_state got cnt %0d v %b exp 1 0", count, data_valid);
        end
        step(1'b0, '0, 1'b1);
        checks++; if (data_out !== v || data_valid !== 1'b1) begin errors++; $display("FAIL ppe_data got %h exp %h", data_out, v); end
    endtask

    task automatic test_random();
        logic we;
        logic re;
        for (int i = 0; i < 400; i++) begin
            we = ($urandom_range(0, 99) < ((i / 50) % 2 == 0 ? 70 : 35));
            re = ($urandom_range(0, 99) < ((i / 50) % 2 == 0 ? 35 : 70));
            step(we, DW'($urandom_range(0, 1023)), re);
            checks++;
            if (count !== 4'(exp_q.size()) || data_out !== exp_dout || data_valid !== exp_valid ||
                full !== (exp_q.size() == DEPTH) || empty !== (exp_q.size() == 0) ||
                almost_full !== (exp_q.size() >= 6) || almost_empty !== (exp_q.size() <= 2) ||
                err_overflow !== exp_ovf || err_underflow !== exp_unf) begin
                errors++;
                $display("FAIL random step %0d got cnt %0d d %h v %b f %b e %b af %b ae %b o %b u %b exp cnt %0d d %h v %b o %b u %b",
                         i, count, data_out, data_valid, full, empty, almost_full, almost_empty,
                         err_overflow, err_underflow, exp_q.size(), exp_dout, exp_valid, exp_ovf, exp_unf);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [DW-1:0] v;
        while (exp_q.size() > 0) step(1'b0, '0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, DW'($urandom_range(1, 1023)), 1'b0);
        checks++; if (count !== 4'd5) begin errors++; $display("FAIL arst_pre got %0d exp 5", count); end
        #3 reset_L = 1'b0;
        #1;
        model_clear();
        checks++; if (count !== 4'd0 || empty !== 1'b1 || almost_empty !== 1'b1) begin
            errors++; $display("FAIL arst_count got cnt %0d e %b ae %b exp 0 1 1", count, empty, almost_empty);
        end
        checks++; if ({full, almost_full, data_valid, err_overflow, err_underflow} !== 5'b0 || data_out !== 10'h000) begin
            errors++; $display("FAIL arst_misc got %b d %h exp 00000 000", {full, almost_full, data_valid, err_overflow, err_underflow}, data_out);
        end
        #2 reset_L = 1'b1;
        @(posedge clk);
        #1;
        v = DW'($urandom_range(0, 1023));
        step(1'b1, v, 1'b0);
        step(1'b0, '0, 1'b1);
        checks++; if (data_out !== v || data_valid !== 1'b1 || empty !== 1'b1) begin
            errors++; $display("FAIL arst_after got %h/%b exp %h/1", data_out, data_valid, v);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_overflow();
        test_underflow();
        test_back_to_back();
        test_push_pop_empty();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
